// File: rtl/rename_stage.sv
// Register-rename stage: map table, circular physical-register free list and a
// single branch checkpoint, feeding a one-entry output register to dispatch.

package types_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  Opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        fu_alu;
    logic        fu_br;
    logic        fu_mem;
  } decode_data;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  Opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        fu_alu;
    logic        fu_br;
    logic        fu_mem;
    logic [6:0]  ps1;
    logic [6:0]  ps2;
    logic [6:0]  pd_new;
    logic [6:0]  pd_old;
  } rename_data;

endpackage

module rename_stage
  import types_pkg::*;
#(
  parameter int NUM_AREG = 32,
  parameter int NUM_PREG = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  decode_data       data_in,
  output logic             ready_in,
  output logic             valid_out,
  output rename_data       data_out,
  input  logic             ready_out,
  input  logic             retire_valid,
  input  logic [6:0]       retire_pd_old,
  input  logic             mispredict,
  input  logic             branch_resolved,
  output logic [7:0]       free_count
);

  localparam int TW        = $clog2(NUM_PREG);
  localparam int FREE_INIT = NUM_PREG - NUM_AREG;

  logic [TW-1:0] map_q      [NUM_AREG];
  logic [TW-1:0] ckptMap_q  [NUM_AREG];
  logic [TW-1:0] freeList_q [NUM_PREG];
  logic [TW-1:0] head_q;
  logic [TW-1:0] tail_q;
  logic [TW-1:0] ckptHead_q;
  logic          ckptValid_q;
  logic          validOut_q;
  rename_data    dataOut_q;

  logic [TW-1:0] map_d [NUM_AREG];
  logic [TW-1:0] head_d;
  logic [TW-1:0] occupancy;
  logic [TW-1:0] allocPd;
  logic          needsAlloc;
  logic          outFree;
  logic          accept;
  logic          retirePush;
  rename_data    packet;

  assign occupancy  = tail_q - head_q;
  assign free_count = {1'b0, occupancy};
  assign needsAlloc = data_in.rd_we && (data_in.rd != 5'd0);
  assign outFree    = !validOut_q || ready_out;
  assign ready_in   = outFree
                   && !(needsAlloc && (occupancy == '0))
                   && !(data_in.fu_br && ckptValid_q)
                   && !mispredict;
  assign accept     = valid_in && ready_in;
  assign allocPd    = freeList_q[head_q];
  assign retirePush = retire_valid && (retire_pd_old != 7'd0);
  assign head_d     = needsAlloc ? head_q + TW'(1) : head_q;

  assign valid_out  = validOut_q;
  assign data_out   = dataOut_q;

  // Post-rename view of the map; a branch checkpoint must include its own rd write.
  always_comb begin
    map_d = map_q;
    if (needsAlloc) begin
      map_d[data_in.rd] = allocPd;
    end
  end

  always_comb begin
    packet        = '0;
    packet.pc     = data_in.pc;
    packet.Opcode = data_in.Opcode;
    packet.func3  = data_in.func3;
    packet.func7  = data_in.func7;
    packet.imm    = data_in.imm;
    packet.rs1    = data_in.rs1;
    packet.rs2    = data_in.rs2;
    packet.rd     = data_in.rd;
    packet.rd_we  = data_in.rd_we;
    packet.fu_alu = data_in.fu_alu;
    packet.fu_br  = data_in.fu_br;
    packet.fu_mem = data_in.fu_mem;
    packet.ps1    = map_q[data_in.rs1];
    packet.ps2    = map_q[data_in.rs2];
    if (needsAlloc) begin
      packet.pd_new = allocPd;
      packet.pd_old = map_q[data_in.rd];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        map_q[i]     <= TW'(i);
        ckptMap_q[i] <= TW'(i);
      end
      for (int i = 0; i < NUM_PREG; i++) begin
        freeList_q[i] <= (i < FREE_INIT) ? TW'(i + NUM_AREG) : '0;
      end
      head_q      <= '0;
      tail_q      <= TW'(FREE_INIT);
      ckptHead_q  <= '0;
      ckptValid_q <= 1'b0;
      validOut_q  <= 1'b0;
      dataOut_q   <= '0;
    end else begin
      // Retirement frees a register regardless of flushes; the pop reads pre-push state.
      if (retirePush) begin
        freeList_q[tail_q] <= retire_pd_old;
        tail_q             <= tail_q + TW'(1);
      end
      if (mispredict) begin
        validOut_q  <= 1'b0;
        ckptValid_q <= 1'b0;
        if (ckptValid_q) begin
          map_q  <= ckptMap_q;
          head_q <= ckptHead_q;
        end
      end else begin
        if (branch_resolved) begin
          ckptValid_q <= 1'b0;
        end
        if (accept) begin
          validOut_q <= 1'b1;
          dataOut_q  <= packet;
          map_q      <= map_d;
          head_q     <= head_d;
          if (data_in.fu_br) begin
            ckptMap_q   <= map_d;
            ckptHead_q  <= head_d;
            ckptValid_q <= 1'b1;
          end
        end else if (ready_out) begin
          validOut_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: a vector table for the basic rename flow plus
// hand-built sequences for free-list exhaustion, checkpoint/mispredict and reset.

module tb_rename_stage;
  import types_pkg::*;

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    logic       br;
    logic       rdyOut;
    logic       retV;
    logic [6:0] retPd;
    logic       misp;
    logic       res;
    logic       expRdy;
    logic       expVld;
    logic       chkData;
    logic [6:0] expPs1;
    logic [6:0] expPs2;
    logic [6:0] expNew;
    logic [6:0] expOld;
    logic [7:0] expFc;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetN;
  logic       validIn;
  decode_data dataIn;
  logic       readyIn;
  logic       validOut;
  rename_data dataOut;
  logic       readyOut;
  logic       retireValid;
  logic [6:0] retirePdOld;
  logic       mispredict;
  logic       branchResolved;
  logic [7:0] freeCount;

  int          nApplied    = 0;
  int          nMiscompare = 0;
  int          stepIdx     = 0;
  logic [31:0] expPc       = '0;
  logic [6:0]  mdl [32];
  vec_t        tbl [12];

  always #5 clk = ~clk;

  rename_stage dut (
    .clk             (clk),
    .reset           (resetN),
    .valid_in        (validIn),
    .data_in         (dataIn),
    .ready_in        (readyIn),
    .valid_out       (validOut),
    .data_out        (dataOut),
    .ready_out       (readyOut),
    .retire_valid    (retireValid),
    .retire_pd_old   (retirePdOld),
    .mispredict      (mispredict),
    .branch_resolved (branchResolved),
    .free_count      (freeCount)
  );

  function automatic vec_t mkVec(input int vld, input int rs1, input int rs2, input int rd,
                                 input int we, input int br, input int rdyOut, input int retV,
                                 input int retPd, input int misp, input int res,
                                 input int expRdy, input int expVld, input int chkData,
                                 input int ps1, input int ps2, input int pdNew, input int pdOld,
                                 input int fc);
    vec_t v;
    v.vld = 1'(vld);       v.rs1 = 5'(rs1);       v.rs2 = 5'(rs2);    v.rd = 5'(rd);
    v.we = 1'(we);         v.br = 1'(br);         v.rdyOut = 1'(rdyOut);
    v.retV = 1'(retV);     v.retPd = 7'(retPd);   v.misp = 1'(misp);  v.res = 1'(res);
    v.expRdy = 1'(expRdy); v.expVld = 1'(expVld); v.chkData = 1'(chkData);
    v.expPs1 = 7'(ps1);    v.expPs2 = 7'(ps2);    v.expNew = 7'(pdNew);
    v.expOld = 7'(pdOld);  v.expFc = 8'(fc);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nApplied++;
    if (actual !== expected) begin
      nMiscompare++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic driveIdle();
    validIn        = 1'b0;
    dataIn         = '0;
    readyOut       = 1'b1;
    retireValid    = 1'b0;
    retirePdOld    = '0;
    mispredict     = 1'b0;
    branchResolved = 1'b0;
  endtask

  // One cycle: drive at the falling edge, check ready_in, then check registered results after the rising edge.
  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    validIn        = v.vld;
    dataIn         = '0;
    dataIn.rs1     = v.rs1;
    dataIn.rs2     = v.rs2;
    dataIn.rd      = v.rd;
    dataIn.rd_we   = v.we;
    dataIn.fu_br   = v.br;
    dataIn.fu_alu  = !v.br;
    dataIn.pc      = 32'h1000 + 32'(stepIdx) * 32'd4;
    dataIn.imm     = 32'(stepIdx);
    readyOut       = v.rdyOut;
    retireValid    = v.retV;
    retirePdOld    = v.retPd;
    mispredict     = v.misp;
    branchResolved = v.res;
    stepIdx++;
    #1;
    checkOutput($sformatf("%s.ready_in", tag), 32'(readyIn), 32'(v.expRdy));
    if (v.vld && v.expRdy) expPc = dataIn.pc;
    @(posedge clk);
    #1;
    checkOutput($sformatf("%s.valid_out", tag), 32'(validOut), 32'(v.expVld));
    checkOutput($sformatf("%s.free_count", tag), 32'(freeCount), 32'(v.expFc));
    if (v.chkData) begin
      checkOutput($sformatf("%s.ps1", tag), 32'(dataOut.ps1), 32'(v.expPs1));
      checkOutput($sformatf("%s.ps2", tag), 32'(dataOut.ps2), 32'(v.expPs2));
      checkOutput($sformatf("%s.pd_new", tag), 32'(dataOut.pd_new), 32'(v.expNew));
      checkOutput($sformatf("%s.pd_old", tag), 32'(dataOut.pd_old), 32'(v.expOld));
      checkOutput($sformatf("%s.pc", tag), dataOut.pc, expPc);
    end
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    driveIdle();
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    #1;
    checkOutput($sformatf("%s.rst_valid_out", tag), 32'(validOut), 32'd0);
    checkOutput($sformatf("%s.rst_free_count", tag), 32'(freeCount), 32'd96);
    checkOutput($sformatf("%s.rst_ready_in", tag), 32'(readyIn), 32'd1);
    checkOutput($sformatf("%s.rst_data_zero", tag), 32'(dataOut != '0), 32'd0);
    for (int i = 0; i < 32; i++) mdl[i] = 7'(i);
  endtask

  initial begin
    resetN = 1'b0;
    driveIdle();

    // vld rs1 rs2 rd we br rdyOut retV retPd misp res | rdy vld chk ps1 ps2 new old fc
    tbl[0]  = mkVec(1, 1, 2,  5, 1, 0, 1, 0,  0, 0, 0,  1, 1, 1,  1,  2, 32,  5, 95);
    tbl[1]  = mkVec(1, 5, 5,  6, 1, 0, 1, 0,  0, 0, 0,  1, 1, 1, 32, 32, 33,  6, 94);
    tbl[2]  = mkVec(0, 0, 0,  0, 0, 0, 1, 0,  0, 0, 0,  1, 0, 0,  0,  0,  0,  0, 94);
    tbl[3]  = mkVec(1, 5, 6,  7, 1, 0, 1, 1,  5, 0, 0,  1, 1, 1, 32, 33, 34,  7, 94);
    tbl[4]  = mkVec(0, 0, 0,  0, 0, 0, 1, 1,  0, 0, 0,  1, 0, 0,  0,  0,  0,  0, 94);
    tbl[5]  = mkVec(1, 7, 6,  9, 0, 0, 1, 0,  0, 0, 0,  1, 1, 1, 34, 33,  0,  0, 94);
    tbl[6]  = mkVec(1, 0, 5,  0, 1, 0, 1, 0,  0, 0, 0,  1, 1, 1,  0, 32,  0,  0, 94);
    tbl[7]  = mkVec(1, 7, 0,  8, 1, 0, 0, 0,  0, 0, 0,  0, 1, 1,  0, 32,  0,  0, 94);
    tbl[8]  = mkVec(1, 7, 0,  8, 1, 0, 1, 0,  0, 0, 0,  1, 1, 1, 34,  0, 35,  8, 93);
    tbl[9]  = mkVec(1, 8, 8,  9, 1, 0, 1, 1, 32, 0, 0,  1, 1, 1, 35, 35, 36,  9, 93);
    tbl[10] = mkVec(1, 9, 0, 10, 1, 0, 0, 0,  0, 1, 0,  0, 0, 0,  0,  0,  0,  0, 93);
    tbl[11] = mkVec(1, 9, 0, 10, 1, 0, 1, 0,  0, 0, 0,  1, 1, 1, 36,  0, 37, 10, 92);

    doReset("table");
    for (int i = 0; i < 12; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

    // Exhaust the free list, recycle one register, then rename to x0 while empty.
    doReset("exhaust");
    for (int i = 0; i < 96; i++) begin
      int rd;
      int old;
      rd  = (i % 31) + 1;
      old = int'(mdl[rd]);
      applyStimulus(mkVec(1, 0, 0, rd, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 32 + i, old, 95 - i),
                    $sformatf("alloc%0d", i));
      mdl[rd] = 7'(32 + i);
    end
    applyStimulus(mkVec(1, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "empty_stall");
    applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1), "retire5");
    applyStimulus(mkVec(1, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 5, int'(mdl[3]), 0), "realloc5");
    mdl[3] = 7'd5;
    applyStimulus(mkVec(1, 3, 5, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 5, int'(mdl[5]), 0, 0, 0), "rd_x0_empty");
    applyStimulus(mkVec(1, 3, 3, 4, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 5, 5, 0, 0, 0), "no_we_empty");

    // Checkpoint, mispredict rollback, branch stall and mispredict-beats-resolve.
    doReset("branch");
    applyStimulus(mkVec(1, 0, 0, 1, 1, 1, 1, 0,  0, 0, 0, 1, 1, 1,  0,  0, 32,  1, 95), "jal");
    applyStimulus(mkVec(1, 1, 0, 7, 1, 0, 1, 0,  0, 0, 0, 1, 1, 1, 32,  0, 33,  7, 94), "spec_add");
    applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0,  0,  0,  0,  0, 95), "misp");
    applyStimulus(mkVec(1, 7, 1, 7, 1, 0, 1, 0,  0, 0, 0, 1, 1, 1,  7, 32, 33,  7, 94), "redo_add");
    applyStimulus(mkVec(1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 1, 1,  0,  0,  0,  0, 94), "br_b");
    applyStimulus(mkVec(1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 94), "br_c_stall");
    applyStimulus(mkVec(1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 1, 0, 0, 0,  0,  0,  0,  0, 94), "br_c_resolve");
    applyStimulus(mkVec(1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 1, 1, 1,  0,  0,  0,  0, 94), "br_c_go");
    applyStimulus(mkVec(1, 7, 0, 7, 1, 0, 1, 0,  0, 0, 0, 1, 1, 1, 33,  0, 34, 33, 93), "spec_add2");
    applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 1, 1, 40, 1, 1, 0, 0, 0,  0,  0,  0,  0, 95), "misp_res_ret");
    applyStimulus(mkVec(1, 7, 0, 7, 1, 0, 1, 0,  0, 0, 0, 1, 1, 1, 33,  0, 34, 33, 94), "redo_add2");

    // Output backpressure followed by an asynchronous reset in the middle of the stall.
    doReset("stall");
    applyStimulus(mkVec(1, 1, 2, 5, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 2, 32, 5, 95), "first");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkVec(1, 5, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 32, 5, 95),
                    $sformatf("hold%0d", i));
    end
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    checkOutput("async_rst.valid_out", 32'(validOut), 32'd0);
    checkOutput("async_rst.free_count", 32'(freeCount), 32'd96);
    checkOutput("async_rst.pd_new", 32'(dataOut.pd_new), 32'd0);
    @(negedge clk);
    driveIdle();
    resetN = 1'b1;
    #1;
    checkOutput("async_rst.ready_in", 32'(readyIn), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
    $finish;
  end

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Register-rename stage sitting directly upstream of dispatch. Consumes decoded instructions and produces the rename_data packet that dispatch buffers.
- Owns the architectural-to-physical map table, the physical-register free list and one branch checkpoint.
- Recycles pd_old returned by ROB retirement. Rolls back map and free list on mispredict.

Parameters:
- NUM_AREG, 32, architectural registers (x0 pinned to p0).
- NUM_PREG, 128, physical registers; tags are $clog2(NUM_PREG)=7 bits.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  decoded instruction valid.
- data_in  in  decode_data  decoded instruction (types_pkg). Used fields: rs1, rs2, rd, rd_we, fu_alu/fu_br/fu_mem, Opcode, func3, func7, imm, pc.
- ready_in  out  1  stage can accept data_in this cycle.
- valid_out  out  1  renamed packet valid to dispatch.
- data_out  out  rename_data  renamed packet: ps1, ps2, pd_new, pd_old plus pass-through fields.
- ready_out  in  1  dispatch ready.
- retire_valid  in  1  ROB retired an instruction.
- retire_pd_old  in  7  physical register freed by retirement.
- mispredict  in  1  flush and restore from checkpoint.
- branch_resolved  in  1  outstanding branch resolved correctly; release checkpoint.
- free_count  out  8  current free-list occupancy (debug/verification).

Behaviour:
- Reset state:
  - map[i]=i for i=0..31.
  - Free list holds p32..p127 in ascending order: head=0, tail=96, count=96.
  - ckpt_valid=0, valid_out=0, data_out='0, free_count=96.
  - ready_in=1 after reset deasserts.
- Allocation condition: needs_alloc = rd_we && rd!=0.
- ready_in = (!valid_out || ready_out) && !(needs_alloc && count==0) && !(data_in.fu_br && ckpt_valid) && !mispredict.
- Accept = valid_in && ready_in. Latency 1 cycle.
- On accept, the output register loads:
  - ps1=map[rs1], ps2=map[rs2] (x0 reads p0).
  - If needs_alloc: pd_new=freelist[head], pd_old=map[rd]; write map[rd]=pd_new; head++.
  - Else: pd_new=0, pd_old=0, no map write.
  - All other fields pass through unchanged.
- Map write is registered. The next accepted instruction sees the updated mapping, so back-to-back RAW dependencies need no stall.
- Output handshake:
  - valid_out/data_out hold stable while valid_out && !ready_out.
  - valid_out clears on a transfer with no new accept.
- Free list: circular, 128 entries, 7-bit head/tail wrapping modulo 128.
  - count = tail-head as an 8-bit value.
  - Retire: if retire_valid && retire_pd_old!=0, write freelist[tail]=retire_pd_old; tail++.
  - Retire push and allocation pop in the same cycle both occur. The pop uses pre-push contents (no bypass), so net count is unchanged.
- Checkpoint:
  - Taken when an fu_br instruction is accepted: ckpt_map = map including that instruction's own rd update (JAL/JALR), and ckpt_head = head after its allocation. ckpt_valid=1.
  - A second branch stalls (ready_in=0) while ckpt_valid.
  - branch_resolved clears ckpt_valid.
- Mispredict (highest priority):
  - If ckpt_valid: map=ckpt_map, head=ckpt_head.
  - tail is not restored; retires in flight remain freed.
  - ckpt_valid=0, valid_out=0, no accept that cycle.
  - A retire in the same cycle is still pushed.
  - mispredict with ckpt_valid=0 only flushes valid_out.
- branch_resolved and mispredict in the same cycle: mispredict wins.
- Reset mid-operation: asynchronously returns to the reset state and drops any in-flight output packet.
- Invariant: count never exceeds 96. Retire of p0 is ignored.

Test Plan:
1. Reset, then rename add x5,x1,x2 (ready_out=1) -> next cycle valid_out=1, ps1=1, ps2=2, pd_new=32, pd_old=5; free_count=95.
2. Back-to-back add x5 then sub x6,x5,x5 -> second packet ps1=ps2=32, pd_new=33, pd_old=6.
3. 96 allocations with no retire -> ready_in=0 and free_count=0. Then retire_pd_old=5 -> free_count=1; next allocation gets pd_new=5.
4. rd=x0 (or rd_we=0) with free_count=0 -> accepted; pd_new=0, pd_old=0, free_count unchanged.
5. Branch (free_count=95), then add x7 (pd_new=33), then mispredict -> map[7]=7 and free_count=95. Next add x7 gets pd_new=33, pd_old=7. A second branch while ckpt_valid stalls until branch_resolved.
6. ready_out=0 for 3 cycles with valid_out=1 -> data_out stable and ready_in=0. Assert reset mid-stall -> valid_out=0 immediately and free_count=96.
